store_table_words: RTL and testbench
====================================

# store_table_words

Writer that fills the byte-wide parameter memory with the 16-bit tables consumed by the routing-metric readers: the Q-value table (64 words at 0x01C8–0x0247) or the HCM table (11 words at 0x0648–0x065D). It accepts words over a valid/ready stream, splits each word into two byte writes (little-endian: low byte at the even address), and signals completion. It sits between the host/learning logic that produces table values and the shared memory that the best-value search reads at word stride 2.

## Interface
- WORD_WIDTH, 16, stream word width
- MEM_WIDTH, 8, memory data width (must be WORD_WIDTH/2)
- Q_BASE, 16'h01C8, Q-value table base byte address
- Q_COUNT, 64, Q-value table length in words
- HCM_BASE, 16'h0648, HCM table base byte address
- HCM_COUNT, 11, HCM table length in words
- clock  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a table write; sampled only in IDLE and DONE
- region  in  1  table select, sampled with start: 0 = Q, 1 = HCM
- in_valid  in  1  in_data holds a word
- in_ready  out  1  block accepts a word this cycle
- in_data  in  16  table word, written in order, index 0 first
- mem_addr  out  16  byte address of the current write
- mem_wdata  out  8  byte to write
- mem_we  out  1  write strobe, one byte per cycle
- busy  out  1  high from accepted start until last byte written
- done  out  1  high in DONE, held until next start or reset
- words_written  out  8  words fully written in the current/last pass

## Operation
- States: IDLE, WAIT, WR_LO, WR_HI, DONE.
- IDLE: in_ready=0, mem_we=0. start=1 → latch base/limit from region, index i=0, words_written=0, → WAIT.
- WAIT: in_ready=1. in_valid=1 → capture in_data, → WR_LO; else stay.
- WR_LO: mem_we=1, mem_addr=base+2i, mem_wdata=word[7:0]; → WR_HI. in_ready=0.
- WR_HI: mem_we=1, mem_addr=base+2i+1, mem_wdata=word[15:8]; words_written increments at the end of this cycle.
  - i==limit-1: in_ready=0, → DONE.
  - else i←i+1; in_ready=1; in_valid=1 → capture next word, → WR_LO (2 cycles/word sustained); else → WAIT.
- DONE: done=1, busy=0, in_ready=0. start=1 → same as IDLE start (done clears next cycle).
- start in WAIT/WR_LO/WR_HI ignored; region only sampled on an accepted start.
- in_valid outside in_ready cycles ignored; no word consumed.
- Address: base + 2i computed mod 2^16; no wrap with default parameters.
- Memory receives exactly 2×limit strobes per pass, addresses strictly ascending by 1.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0, state IDLE.
- rst overrides everything; asserted mid-pass → mem_we=0 from the next cycle, partial table left in memory, no done.
- start at edge N → WAIT at N+1, in_ready high in cycle N+1.
- Word accepted at edge M → low-byte strobe cycle M+1, high-byte strobe cycle M+2.
- Back-to-back stream: n words complete in 1 + 2n cycles after start; done high the cycle after the last WR_HI.
- busy = state in {WAIT, WR_LO, WR_HI}.
- mem_addr/mem_wdata hold last values when mem_we=0; only valid with mem_we=1.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, IDLE; in_valid=1 with no start → no mem_we, in_ready stays 0.
- Q pass, in_valid always high, data = 16'hA500+i → 128 strobes, addr 0x01C8..0x0247, byte at 0x01C8=0x00, 0x01C9=0xA5, 0x0247=0xA5; done at cycle 130 after start; words_written=64.
- HCM pass with in_valid high every third cycle, data = 16'h1000·i+i → 22 strobes at 0x0648..0x065D, correct bytes, no strobe during gaps, words_written=11.
- start pulsed with region toggled mid-Q-pass → ignored; addresses stay in Q range; single done at end.
- rst asserted after 5th word's WR_LO → next cycle mem_we=0, busy=0, done=0; new start then completes a full pass normally.
- From DONE, start with region=1 → done low next cycle, HCM pass completes, words_written resets to 0 then reaches 11.

Source files
------------

// File: rtl/store_table_words_if.sv
// Stream-in / byte-write-out bundle for the table writer.
// The host drives start, region and the word stream; the writer drives the memory port and status.
interface store_table_words_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MEM_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  start;
    logic                  region;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  words_written;

    modport master (
        output start, region, in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, mem_we, busy, done, words_written
    );

    modport slave (
        input  start, region, in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, mem_we, busy, done, words_written
    );
endinterface

// File: rtl/store_table_words.sv
// Writes a stream of 16-bit table words into byte-wide parameter memory,
// low byte at the even address, for either the Q-value or the HCM table.
module store_table_words #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MEM_WIDTH  = 8,
    parameter logic [15:0] Q_BASE     = 16'h01C8,
    parameter int unsigned Q_COUNT    = 64,
    parameter logic [15:0] HCM_BASE   = 16'h0648,
    parameter int unsigned HCM_COUNT  = 11
) (
    input  logic                clock,
    input  logic                rst,
    store_table_words_if.slave  bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [CNT_W-1:0]      limit_q, limit_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_q;
    logic                  last_d;
    logic [ADDR_W-1:0]     addr_even_d;

    assign last_q = (idx_q == CNT_W'(limit_q - CNT_W'(1)));

    // Next-state, datapath and next-cycle output values
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        limit_d     = limit_q;
        idx_d       = idx_q;
        word_d      = word_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    base_d  = bus.region ? HCM_BASE : Q_BASE;
                    limit_d = bus.region ? CNT_W'(HCM_COUNT) : CNT_W'(Q_COUNT);
                    idx_d   = '0;
                    count_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                count_d = CNT_W'(count_q + CNT_W'(1));
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = CNT_W'(idx_q + CNT_W'(1));
                    if (bus.in_valid) begin
                        word_d  = bus.in_data;
                        state_d = S_WR_LO;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte strobe for the state being entered; address wraps mod 2^16
        addr_even_d = ADDR_W'(base_d + (ADDR_W'(idx_d) << 1));
        if (state_d == S_WR_LO) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_even_d;
            mem_wdata_d = word_d[MEM_WIDTH-1:0];
        end else if (state_d == S_WR_HI) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(addr_even_d + ADDR_W'(1));
            mem_wdata_d = word_d[WORD_WIDTH-1 -: MEM_WIDTH];
        end

        last_d     = (idx_d == CNT_W'(limit_d - CNT_W'(1)));
        in_ready_d = (state_d == S_WAIT) || ((state_d == S_WR_HI) && !last_d);
        busy_d     = (state_d == S_WAIT) || (state_d == S_WR_LO) || (state_d == S_WR_HI);
        done_d     = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            limit_q     <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.words_written = count_q;
endmodule

// File: tb/tb_store_table_words.sv
// Randomized scoreboard bench for store_table_words: the driver pushes expected
// byte writes per accepted word, a monitor pops and compares every strobe.
module tb_store_table_words;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    store_table_words_if bus ();

    store_table_words dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t       exp_q[$];
    logic [7:0] mem_img [logic [15:0]];
    int         n_chk      = 0;
    int         n_fail     = 0;
    int         strobes    = 0;
    int         done_rises = 0;
    logic       done_prev  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: every strobe must match the oldest expected byte write
    always @(negedge clock) begin
        exp_t e;
        if (bus.mem_we === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                chk("strobe_expected", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
            end
            mem_img[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.done === 1'b1 && done_prev !== 1'b1) done_rises++;
        done_prev = bus.done;
    end

    // One table pass: start, feed n words, then check completion status
    task automatic run_pass(input bit rgn, input int n, input int period, input int dmode,
                            input int toggle_at, input int reset_after);
        logic [15:0] base;
        logic [15:0] w;
        bit          v;
        bit          was_reset;
        int          k, c, done_c, acc_c, s0, r0;
        base      = rgn ? 16'h0648 : 16'h01C8;
        s0        = strobes;
        r0        = done_rises;
        k         = 0;
        c         = 0;
        done_c    = -1;
        acc_c     = -1;
        was_reset = 1'b0;
        bus.start    = 1'b1;
        bus.region   = rgn;
        bus.in_valid = 1'b0;
        while (c < 3000 && done_c < 0 && !was_reset) begin
            @(negedge clock);
            c++;
            bus.start = (c == toggle_at);
            if (c == toggle_at) bus.region = ~rgn;
            if (c == 1) begin
                chk("start_busy", 32'(bus.busy), 32'd1);
                chk("start_in_ready", 32'(bus.in_ready), 32'd1);
                chk("start_done_clear", 32'(bus.done), 32'd0);
                chk("start_words_clear", 32'(bus.words_written), 32'd0);
            end
            if (bus.done === 1'b1) begin
                done_c       = c;
                bus.in_valid = 1'b0;
            end else if (acc_c >= 0 && c == acc_c + 2) begin
                rst          = 1'b1;
                bus.in_valid = 1'b0;
                was_reset    = 1'b1;
            end else if (k < n) begin
                v = (period == 0) ? 1'($urandom_range(0, 1)) : ((c - 1) % period == 0);
                case (dmode)
                    0:       w = 16'hA500 + 16'(k);
                    1:       w = 16'(k * 16'h1000 + k);
                    default: w = 16'($urandom);
                endcase
                bus.in_valid = v;
                bus.in_data  = w;
                if (v && bus.in_ready === 1'b1) begin
                    exp_q.push_back('{addr: 16'(base + 16'(2 * k)),     data: w[7:0]});
                    exp_q.push_back('{addr: 16'(base + 16'(2 * k + 1)), data: w[15:8]});
                    k++;
                    if (k == reset_after) acc_c = c;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.start = 1'b0;
        @(negedge clock);
        if (was_reset) begin
            chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_words", 32'(bus.words_written), 32'd0);
            chk("rst_pending", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            rst = 1'b0;
        end else if (done_c < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("words_written", 32'(bus.words_written), 32'(n));
            chk("strobe_count", 32'(strobes - s0), 32'(2 * n));
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("single_done", 32'(done_rises - r0), 32'd1);
            chk("done_held", 32'(bus.done), 32'd1);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("done_in_ready", 32'(bus.in_ready), 32'd0);
            if (period == 1 && toggle_at < 0) chk("done_latency", 32'(done_c), 32'(2 * n + 2));
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.region   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_words", 32'(bus.words_written), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
            chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
        end
        bus.in_valid = 1'b0;

        // Q table, back-to-back stream
        run_pass(1'b0, 64, 1, 0, -1, -1);
        chk("q_byte_01c8", 32'(mem_img[16'h01C8]), 32'h00);
        chk("q_byte_01c9", 32'(mem_img[16'h01C9]), 32'hA5);
        chk("q_byte_0246", 32'(mem_img[16'h0246]), 32'h3F);
        chk("q_byte_0247", 32'(mem_img[16'h0247]), 32'hA5);

        // HCM table, one valid every third cycle
        run_pass(1'b1, 11, 3, 1, -1, -1);
        chk("hcm_byte_0648", 32'(mem_img[16'h0648]), 32'h00);
        chk("hcm_byte_064a", 32'(mem_img[16'h064A]), 32'h01);
        chk("hcm_byte_064b", 32'(mem_img[16'h064B]), 32'h10);
        chk("hcm_byte_065c", 32'(mem_img[16'h065C]), 32'h0A);
        chk("hcm_byte_065d", 32'(mem_img[16'h065D]), 32'hA0);

        // Q pass with a stray start and flipped region mid-pass
        run_pass(1'b0, 64, 0, 2, 20, -1);

        // Reset during the fifth word, then a clean full pass
        run_pass(1'b0, 64, 1, 2, -1, 5);
        run_pass(1'b0, 64, 0, 2, -1, -1);

        // Restart from DONE into the HCM table
        run_pass(1'b1, 11, 1, 1, -1, -1);
        chk("hcm2_byte_065d", 32'(mem_img[16'h065D]), 32'hA0);

        // Random passes
        for (int p = 0; p < 3; p++) begin
            automatic bit rg = 1'($urandom_range(0, 1));
            run_pass(rg, rg ? 11 : 64, $urandom_range(0, 2), 2, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
